// File: rtl/maze_buffer_ctrl_if.sv
// Request, tile ROM and back-bank write signals shared by game logic and the maze buffer controller.
interface maze_buffer_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_tile_x;
    logic [5:0]  req_tile_y;
    logic [5:0]  req_tile_id;
    logic [11:0] tile_rom_addr;
    logic [7:0]  tile_rom_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output req_valid, req_tile_x, req_tile_y, req_tile_id, tile_rom_data,
        input  req_ready, tile_rom_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_tile_x, req_tile_y, req_tile_id, tile_rom_data,
        output req_ready, tile_rom_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/maze_buffer_ctrl.sv
// Ping-pong maze framebuffer controller: queues tile updates, writes each into the back bank,
// swaps banks at vertical blank, then replays the update into the new back bank.
//
// state       | meaning
// S_IDLE      | waiting for a queued update; drops out-of-range entries
// S_WRITE     | 65-cycle tile copy, ROM address k=0..63, RAM write k=1..64
// S_WAIT_SWAP | first pass done; waiting for the frame boundary to swap banks
module maze_buffer_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ROW_PITCH  = 264,
    parameter int unsigned TILES_X    = 30,
    parameter int unsigned TILES_Y    = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         hc,
    input  logic [9:0]         vc,
    maze_buffer_ctrl_if.slave  bus,
    output logic               front_sel,
    output logic               swap_pulse,
    output logic               busy
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE     = 2'd1,
        S_WAIT_SWAP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  k, k_nxt;
    logic        pass, pass_nxt;
    logic        pop, push, do_swap;
    logic        frame_edge;
    logic        out_of_range;
    logic        wr_en_q;
    logic [15:0] wr_addr_q;

    logic [16:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [4:0]  head_x;
    logic [5:0]  head_y;
    logic [5:0]  head_id;
    logic [15:0] col, row, pix_addr;

    assign bus.req_ready = (count != CNT_W'(FIFO_DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign busy          = (count != '0) || (state != S_IDLE);

    assign {head_x, head_y, head_id} = fifo_mem[rd_ptr];
    assign out_of_range = (7'(head_x) >= 7'(TILES_X)) || (7'(head_y) >= 7'(TILES_Y));
    assign frame_edge   = (vc == 10'd480) && (hc == 10'd0);

    // Column-major bank layout: xpos selects a 264-word column, ypos indexes within it.
    assign col      = 16'({head_x, 3'b000}) + 16'(k[5:3]);
    assign row      = 16'({head_y, 3'b000}) + 16'(k[2:0]);
    assign pix_addr = col * 16'(ROW_PITCH) + row;

    assign bus.tile_rom_addr = (state == S_WRITE && !k[6]) ? {head_id, k[5:0]} : 12'd0;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data       = bus.tile_rom_data;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.req_tile_x, bus.req_tile_y, bus.req_tile_id};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        pass_nxt  = pass;
        pop       = 1'b0;
        do_swap   = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    if (out_of_range) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = S_WRITE;
                        k_nxt     = '0;
                        pass_nxt  = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                k_nxt = k + 7'd1;
                if (k == 7'd64) begin
                    k_nxt = '0;
                    if (!pass) begin
                        pass_nxt  = 1'b1;
                        state_nxt = S_WAIT_SWAP;
                    end else begin
                        pass_nxt  = 1'b0;
                        pop       = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_SWAP: begin
                // Swap lands on the boundary edge; the replay starts the cycle after the pulse.
                if (swap_pulse) begin
                    state_nxt = S_WRITE;
                    k_nxt     = '0;
                end else if (frame_edge) begin
                    do_swap = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            k          <= '0;
            pass       <= 1'b0;
            front_sel  <= 1'b0;
            swap_pulse <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state      <= state_nxt;
            k          <= k_nxt;
            pass       <= pass_nxt;
            swap_pulse <= do_swap;
            if (do_swap) front_sel <= ~front_sel;
            wr_en_q <= (state == S_WRITE) && !k[6];
            if (state == S_WRITE && !k[6]) wr_addr_q <= pix_addr;
        end
    end
endmodule

// File: tb/tb_maze_buffer_ctrl.sv
// Scoreboard bench for maze_buffer_ctrl: expected writes and swaps are queued as stimulus is
// issued and a negedge monitor pops and compares them; timing points are checked inline.
module tb_maze_buffer_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] hc  = 10'd1;
    logic [9:0] vc  = 10'd0;
    logic       front_sel;
    logic       swap_pulse;
    logic       busy;

    maze_buffer_ctrl_if bus();

    maze_buffer_ctrl #(
        .FIFO_DEPTH(4),
        .ROW_PITCH (264),
        .TILES_X   (30),
        .TILES_Y   (33)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hc        (hc),
        .vc        (vc),
        .bus       (bus),
        .front_sel (front_sel),
        .swap_pulse(swap_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int bank;
    } wr_t;

    wr_t wq[$];
    int  sq[$];
    wr_t mon_e;
    int  exp_front  = 0;
    int  n_checks   = 0;
    int  n_fail     = 0;
    int  max_addr   = 0;
    bit  auto_frame = 1'b0;
    int  fcnt       = 0;
    bit  accepted;

    function automatic logic [7:0] rom_fn(input logic [11:0] a);
        return a[7:0] + 8'(a[11:6]) * 8'd37;
    endfunction

    // Registered tile ROM, one cycle of latency.
    initial bus.tile_rom_data = 8'd0;
    always @(posedge clk) bus.tile_rom_data <= rom_fn(bus.tile_rom_addr);

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int x, input int y, input int id);
        bus.req_tile_x  = 5'(x);
        bus.req_tile_y  = 6'(y);
        bus.req_tile_id = 6'(id);
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic frame_edge();
        vc = 10'd480;
        hc = 10'd0;
        @(posedge clk);
        #1;
        vc = 10'd0;
        hc = 10'd1;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("idle_within_budget", int'(busy), 0);
    endtask

    // Two passes per in-range tile: first into the current back bank, then into the old front.
    task automatic expect_tile(input int x, input int y, input int id);
        wr_t e;
        for (int ps = 0; ps < 2; ps++) begin
            for (int p = 0; p < 64; p++) begin
                e.addr = (x * 8 + p / 8) * 264 + y * 8 + p % 8;
                e.data = int'(rom_fn(12'(id * 64 + p)));
                e.bank = (ps == 0) ? 1 - exp_front : exp_front;
                wq.push_back(e);
            end
            if (ps == 0) sq.push_back(1 - exp_front);
        end
        exp_front = 1 - exp_front;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.wr_en) begin
                if (int'(bus.wr_addr) > max_addr) max_addr = int'(bus.wr_addr);
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    mon_e = wq.pop_front();
                    chk("wr_addr", int'(bus.wr_addr), mon_e.addr);
                    chk("wr_data", int'(bus.wr_data), mon_e.data);
                    chk("wr_bank", 1 - int'(front_sel), mon_e.bank);
                end
            end
            if (swap_pulse) begin
                if (sq.size() == 0) chk("unexpected_swap", 1, 0);
                else chk("front_after_swap", int'(front_sel), sq.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_frame) begin
                fcnt++;
                if (fcnt == 100) begin
                    vc   = 10'd480;
                    hc   = 10'd0;
                    fcnt = 0;
                end else begin
                    vc = 10'd0;
                    hc = 10'd1;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_tile_x  = '0;
        bus.req_tile_y  = '0;
        bus.req_tile_id = '0;

        step(3);
        rst = 1'b1;
        chk("rst_front_sel",     int'(front_sel),         0);
        chk("rst_wr_en",         int'(bus.wr_en),         0);
        chk("rst_wr_addr",       int'(bus.wr_addr),       0);
        chk("rst_tile_rom_addr", int'(bus.tile_rom_addr), 0);
        chk("rst_swap_pulse",    int'(swap_pulse),        0);
        chk("rst_busy",          int'(busy),              0);
        chk("rst_req_ready",     int'(bus.req_ready),     1);

        // Single request (0,0,5).
        step(2);
        expect_tile(0, 0, 5);
        push(0, 0, 5);
        step(1);
        chk("single_rom_addr_k0", int'(bus.tile_rom_addr), 320);
        chk("single_no_write_k0", int'(bus.wr_en), 0);
        step(1);
        chk("single_first_wr_en", int'(bus.wr_en), 1);
        chk("single_first_addr",  int'(bus.wr_addr), 0);
        step(9);
        chk("single_addr_p9",     int'(bus.wr_addr), 265);
        step(54);
        chk("single_last_wr_en",  int'(bus.wr_en), 1);
        step(1);
        chk("single_pass1_done",  int'(bus.wr_en), 0);
        chk("single_busy_wait",   int'(busy), 1);
        step(5);
        frame_edge();
        chk("single_swap_pulse",  int'(swap_pulse), 1);
        chk("single_front_sel",   int'(front_sel), 1);
        step(65);
        chk("single_pass2_last",  int'(bus.wr_en), 1);
        step(1);
        chk("single_busy_falls",  int'(busy), 0);

        // Corner tile (29,32).
        step(2);
        expect_tile(29, 32, 63);
        push(29, 32, 63);
        step(2);
        chk("corner_first_addr", int'(bus.wr_addr), 61504);
        step(63);
        chk("corner_last_addr",  int'(bus.wr_addr), 63359);
        step(5);
        frame_edge();
        chk("corner_front_sel",  int'(front_sel), 0);
        wait_idle(200);
        chk("corner_max_addr",   max_addr, 63359);

        // FIFO full: four in-range entries, then an out-of-range fifth held on req_valid.
        auto_frame = 1'b1;
        step(1);
        expect_tile(3, 4, 10);
        expect_tile(4, 5, 11);
        expect_tile(5, 6, 12);
        expect_tile(6, 7, 13);
        push(3, 4, 10);
        push(4, 5, 11);
        push(5, 6, 12);
        push(6, 7, 13);
        chk("fifo_full_ready_low", int'(bus.req_ready), 0);
        bus.req_tile_x  = 5'd31;
        bus.req_tile_y  = 6'd2;
        bus.req_tile_id = 6'd14;
        bus.req_valid   = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 400 && !accepted; i++) begin
            if (bus.req_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk("fifo_fifth_accepted", int'(accepted), 1);
        wait_idle(2000);
        auto_frame = 1'b0;
        step(1);
        vc = 10'd0;
        hc = 10'd1;
        chk("fifo_front_sel_end", int'(front_sel), 0);

        // Out-of-range head followed by (1,1).
        step(2);
        expect_tile(1, 1, 9);
        bus.req_tile_x  = 5'd30;
        bus.req_tile_y  = 6'd0;
        bus.req_tile_id = 6'd3;
        bus.req_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.req_tile_x  = 5'd1;
        bus.req_tile_y  = 6'd1;
        bus.req_tile_id = 6'd9;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        step(1);
        chk("oor_no_early_write",  int'(bus.wr_en), 0);
        step(1);
        chk("oor_next_first_wr",   int'(bus.wr_en), 1);
        chk("oor_next_first_addr", int'(bus.wr_addr), 2120);
        step(70);
        frame_edge();
        chk("oor_swap_pulse", int'(swap_pulse), 1);
        chk("oor_front_sel",  int'(front_sel), 1);
        wait_idle(200);

        // Boundary during WRITE k=30 must not swap.
        step(2);
        expect_tile(2, 3, 7);
        push(2, 3, 7);
        step(31);
        vc = 10'd480;
        hc = 10'd0;
        step(1);
        vc = 10'd0;
        hc = 10'd1;
        chk("midwrite_no_pulse", int'(swap_pulse), 0);
        chk("midwrite_front",    int'(front_sel), 1);
        step(50);
        chk("midwrite_still_busy", int'(busy), 1);
        chk("midwrite_no_swap",    int'(front_sel), 1);
        frame_edge();
        chk("midwrite_late_pulse", int'(swap_pulse), 1);
        chk("midwrite_late_front", int'(front_sel), 0);
        wait_idle(200);

        // Reset at WRITE k=20.
        step(2);
        expect_tile(4, 4, 20);
        push(4, 4, 20);
        step(21);
        rst = 1'b0;
        step(1);
        chk("midrst_wr_en",         int'(bus.wr_en),         0);
        chk("midrst_wr_addr",       int'(bus.wr_addr),       0);
        chk("midrst_tile_rom_addr", int'(bus.tile_rom_addr), 0);
        chk("midrst_swap_pulse",    int'(swap_pulse),        0);
        chk("midrst_front_sel",     int'(front_sel),         0);
        chk("midrst_busy",          int'(busy),              0);
        chk("midrst_req_ready",     int'(bus.req_ready),     1);
        wq.delete();
        sq.delete();
        exp_front = 0;
        rst = 1'b1;
        step(1);
        expect_tile(0, 0, 5);
        push(0, 0, 5);
        step(1);
        chk("postrst_rom_addr_k0", int'(bus.tile_rom_addr), 320);
        step(1);
        chk("postrst_first_wr_en", int'(bus.wr_en), 1);
        chk("postrst_first_addr",  int'(bus.wr_addr), 0);
        step(70);
        frame_edge();
        chk("postrst_front_sel", int'(front_sel), 1);
        wait_idle(200);

        step(2);
        chk("writes_drained", wq.size(), 0);
        chk("swaps_drained",  sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
